bus_arbiter: RTL and testbench

- Responder to the master's request/grant handshake on the shared serial bus.
- Replaces the button-driven grant and the hard-wired arbiter_drive/arb_out in the bring-up top.
- Accepts b_request from up to NUM_MASTERS masters and grants exactly one at a time.
- Tracks b_bus_utilizing to detect end of transaction; revokes stale grants on timeout; drives slave_busy high for a one-cycle guard gap between owners.

---
 rtl/bus_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Request/grant arbiter for the shared serial bus: one owner at a time, stale-grant timeout, one-cycle guard gap.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration; the default build uses fixed priority (lowest index wins).
module bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ID_WIDTH    = 2,
  parameter int TIMEOUT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] b_request,
  input  logic                   b_bus_utilizing,
  output logic [NUM_MASTERS-1:0] b_grant,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic                   arb_busy,
  output logic                   slv_bsy_drv,
  output logic                   timeout_pulse
);

  typedef enum logic [1:0] {IDLE, GRANT_WAIT, BUSY, RELEASE} state_t;

  // Revoke on the edge where the timer would reach its all-ones value.
  localparam logic [TIMEOUT_LEN-1:0] TIMER_LAST = {{(TIMEOUT_LEN-1){1'b1}}, 1'b0};

  state_t                 state;
  logic [TIMEOUT_LEN-1:0] timer;
  logic                   any_req;
  logic                   owner_req;
  logic [ID_WIDTH-1:0]    winner;
  logic [NUM_MASTERS-1:0] winner_onehot;

  function automatic logic [ID_WIDTH-1:0] lowest_set(input logic [NUM_MASTERS-1:0] vec);
    lowest_set = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = ID_WIDTH'(i);
    end
  endfunction

  assign any_req   = |b_request;
  assign owner_req = |(b_request & b_grant);

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
    assign winner_onehot[gi] = (winner == ID_WIDTH'(gi));
  end

`ifdef ARB_ROUND_ROBIN_EN
  // rr_ptr holds the index where the next search begins (last grantee + 1, wrapped).
  logic [ID_WIDTH-1:0]    rr_ptr;
  logic [NUM_MASTERS-1:0] hi_mask;
  logic [NUM_MASTERS-1:0] masked_req;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_hi_mask
    assign hi_mask[gi] = (ID_WIDTH'(gi) >= rr_ptr);
  end

  assign masked_req = b_request & hi_mask;
  assign winner     = (|masked_req) ? lowest_set(masked_req) : lowest_set(b_request);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= (winner == ID_WIDTH'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
    end
  end
`else
  assign winner = lowest_set(b_request);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      b_grant       <= '0;
      grant_id      <= '0;
      arb_busy      <= 1'b0;
      slv_bsy_drv   <= 1'b0;
      timeout_pulse <= 1'b0;
      timer         <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      slv_bsy_drv   <= 1'b0;
      case (state)
        IDLE: begin
          arb_busy <= 1'b0;
          if (any_req) begin
            b_grant  <= winner_onehot;
            grant_id <= winner;
            timer    <= '0;
            arb_busy <= 1'b1;
            state    <= GRANT_WAIT;
          end
        end
        GRANT_WAIT: begin
          // Bus activity beats both withdrawal and expiry in the same cycle.
          if (b_bus_utilizing) begin
            state <= BUSY;
          end else if (!owner_req) begin
            b_grant     <= '0;
            slv_bsy_drv <= 1'b1;
            state       <= RELEASE;
          end else if (timer == TIMER_LAST) begin
            b_grant       <= '0;
            timer         <= timer + 1'b1;
            timeout_pulse <= 1'b1;
            slv_bsy_drv   <= 1'b1;
            state         <= RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BUSY: begin
          if (!b_bus_utilizing) begin
            b_grant     <= '0;
            slv_bsy_drv <= 1'b1;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          b_grant  <= '0;
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter; expectations are queued per step and checked one cycle later.
// Round-robin expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] b_request = 3'b000;
  logic       b_bus_utilizing = 1'b0;
  logic [2:0] b_grant;
  logic [1:0] grant_id;
  logic       arb_busy;
  logic       slv_bsy_drv;
  logic       timeout_pulse;

  bus_arbiter #(
    .NUM_MASTERS(3),
    .ID_WIDTH   (2),
    .TIMEOUT_LEN(4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .b_request      (b_request),
    .b_bus_utilizing(b_bus_utilizing),
    .b_grant        (b_grant),
    .grant_id       (grant_id),
    .arb_busy       (arb_busy),
    .slv_bsy_drv    (slv_bsy_drv),
    .timeout_pulse  (timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] vec;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Output vector layout: {b_grant[2:0], grant_id[1:0], arb_busy, slv_bsy_drv, timeout_pulse}
  function automatic logic [7:0] pk(input logic [2:0] g, input logic [1:0] id,
                                    input logic busy, input logic slv, input logic pulse);
    return {g, id, busy, slv, pulse};
  endfunction

  task automatic check_out();
    exp_t       e;
    logic [7:0] got;
    got = {b_grant, grant_id, arb_busy, slv_bsy_drv, timeout_pulse};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %h required an expectation entry", got);
    end else begin
      e = sb.pop_front();
      $display("vec %0d %s: out=%h exp=%h", vectors, e.tag, got, e.vec);
      assert (got === e.vec) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, got, e.vec);
      end
    end
  endtask

  // Drive inputs just after an edge, queue the expected outputs for the next edge, then check.
  task automatic step(input string tag, input logic r, input logic [2:0] req,
                      input logic util, input logic [7:0] exp_vec);
    exp_t e;
    rstn            = r;
    b_request       = req;
    b_bus_utilizing = util;
    e.tag = tag;
    e.vec = exp_vec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  logic [1:0] rr_order [4];
  logic [2:0] onehot;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_order = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
    rr_order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    @(posedge clk);
    #1;

    // Reset state
    step("reset_a", 1'b0, 3'b000, 1'b0, pk(3'b000, 2'd0, 0, 0, 0));
    step("reset_b", 1'b0, 3'b111, 1'b1, pk(3'b000, 2'd0, 0, 0, 0));
    step("idle_noreq", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd0, 0, 0, 0));

    // Single master 1, 20-clock bus use
    step("grant_m1", 1'b1, 3'b010, 1'b0, pk(3'b010, 2'd1, 1, 0, 0));
    for (int i = 0; i < 20; i++)
      step($sformatf("busy_m1_%0d", i), 1'b1, 3'b010, 1'b1, pk(3'b010, 2'd1, 1, 0, 0));
    step("release_m1", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd1, 1, 1, 0));
    step("idle_after_m1", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd1, 0, 0, 0));

    // Timeout: grant revoked 15 clocks after it appears, then regrant 2 clocks later
    step("grant_m0_to", 1'b1, 3'b001, 1'b0, pk(3'b001, 2'd0, 1, 0, 0));
    for (int i = 1; i < 15; i++)
      step($sformatf("wait_m0_%0d", i), 1'b1, 3'b001, 1'b0, pk(3'b001, 2'd0, 1, 0, 0));
    step("timeout_revoke", 1'b1, 3'b001, 1'b0, pk(3'b000, 2'd0, 1, 1, 1));
    step("timeout_idle", 1'b1, 3'b001, 1'b0, pk(3'b000, 2'd0, 0, 0, 0));
    step("regrant_m0", 1'b1, 3'b001, 1'b0, pk(3'b001, 2'd0, 1, 0, 0));
    // Withdrawal in GRANT_WAIT: release without pulse
    step("withdraw", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd0, 1, 1, 0));
    step("withdraw_idle", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd0, 0, 0, 0));

    // All three requesting, 5-clock owners; reset first so the pointer starts at 0
    step("reset_rr", 1'b0, 3'b000, 1'b0, pk(3'b000, 2'd0, 0, 0, 0));
    for (int r = 0; r < 4; r++) begin
      onehot = 3'b001 << rr_order[r];
      step($sformatf("rr_grant_%0d", r), 1'b1, 3'b111, 1'b0, pk(onehot, rr_order[r], 1, 0, 0));
      for (int c = 0; c < 5; c++)
        step($sformatf("rr_busy_%0d_%0d", r, c), 1'b1, 3'b111, 1'b1, pk(onehot, rr_order[r], 1, 0, 0));
      step($sformatf("rr_release_%0d", r), 1'b1, 3'b111, 1'b0, pk(3'b000, rr_order[r], 1, 1, 0));
      step($sformatf("rr_idle_%0d", r), 1'b1, 3'b111, 1'b0, pk(3'b000, rr_order[r], 0, 0, 0));
    end

    // Owner 2 withdraws and others request while BUSY: grant holds
    step("grant_m2", 1'b1, 3'b100, 1'b0, pk(3'b100, 2'd2, 1, 0, 0));
    step("busy_m2", 1'b1, 3'b100, 1'b1, pk(3'b100, 2'd2, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      step($sformatf("busy_m2_drop_%0d", i), 1'b1, 3'b000, 1'b1, pk(3'b100, 2'd2, 1, 0, 0));
    step("busy_m2_others", 1'b1, 3'b011, 1'b1, pk(3'b100, 2'd2, 1, 0, 0));
    step("release_m2", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd2, 1, 1, 0));
    step("idle_after_m2", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd2, 0, 0, 0));

    // Reset during BUSY
    step("grant_m1_rst", 1'b1, 3'b010, 1'b0, pk(3'b010, 2'd1, 1, 0, 0));
    step("busy_m1_rst", 1'b1, 3'b010, 1'b1, pk(3'b010, 2'd1, 1, 0, 0));
    step("reset_in_busy", 1'b0, 3'b010, 1'b1, pk(3'b000, 2'd0, 0, 0, 0));
    step("after_reset", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd0, 0, 0, 0));

    // Bus rises on the exact expiry cycle: BUSY wins, no pulse
    step("grant_m0_race", 1'b1, 3'b001, 1'b0, pk(3'b001, 2'd0, 1, 0, 0));
    for (int i = 1; i < 15; i++)
      step($sformatf("race_wait_%0d", i), 1'b1, 3'b001, 1'b0, pk(3'b001, 2'd0, 1, 0, 0));
    step("race_busy", 1'b1, 3'b001, 1'b1, pk(3'b001, 2'd0, 1, 0, 0));
    step("race_hold", 1'b1, 3'b001, 1'b1, pk(3'b001, 2'd0, 1, 0, 0));
    step("race_release", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd0, 1, 1, 0));
    step("race_idle", 1'b1, 3'b000, 1'b0, pk(3'b000, 2'd0, 0, 0, 0));

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
